// File: rtl/vga_axil_pkg.sv
// vga_axil_pkg: shared AXI4-Lite types, native request struct and address conversion
package vga_axil_pkg;
   localparam int AXIL_ADDR_WIDTH = 32;
   localparam int AXIL_DATA_WIDTH = 32;
   localparam int AXIL_STRB_WIDTH = AXIL_DATA_WIDTH/8;
   localparam int NATIVE_ADDR_WIDTH = 29;
   typedef logic [AXIL_ADDR_WIDTH-1:0] axil_addr_t;
   typedef logic [AXIL_DATA_WIDTH-1:0] axil_data_t;
   typedef logic [AXIL_STRB_WIDTH-1:0] axil_strb_t;
   typedef logic [NATIVE_ADDR_WIDTH-1:0] native_addr_t;
   typedef enum logic [1:0] {OKAY = 2'b00, SLVERR = 2'b10} axil_resp_e;
   typedef struct packed {
      logic         we;
      native_addr_t addr;
      axil_data_t   wdata;
      axil_strb_t   wstrb;
   } native_req_t;
   function automatic native_addr_t axil2native_addr(input axil_addr_t a);
      return native_addr_t'(a >> 3);
   endfunction
endpackage

// File: rtl/vga_axil_hold.sv
// vga_axil_hold: one-entry valid/ready holding register with same-cycle bypass view
module vga_axil_hold #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         block,
   input  logic         clr,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         in_ready,
   output logic         avail,
   output logic [W-1:0] data
);
   logic         full;
   logic [W-1:0] q;
   assign in_ready = !full && !block;
   assign avail = full || (in_valid && in_ready);
   assign data = full ? q : in_data;
   always_ff @(posedge clk) begin
      if (rst) begin
         full <= 1'b0;
         q <= '0;
      end else begin
         full <= clr ? 1'b0 : (in_valid && in_ready) ? 1'b1 : full;
         if (in_valid && in_ready) q <= in_data;
      end
   end
endmodule

// File: rtl/vga_axil_slave.sv
// vga_axil_slave: AXI4-Lite slave turning each transaction into one native register access
module vga_axil_slave
   import vga_axil_pkg::*;
#(
   parameter int NATIVE_DEPTH = 16
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  axil_addr_t         s_awaddr_i,
   input  logic               s_awvalid_i,
   output logic               s_awready_o,
   input  axil_data_t         s_wdata_i,
   input  axil_strb_t         s_wstrb_i,
   input  logic               s_wvalid_i,
   output logic               s_wready_o,
   output logic [1:0]         s_bresp_o,
   output logic               s_bvalid_o,
   input  logic               s_bready_i,
   input  axil_addr_t         s_araddr_i,
   input  logic               s_arvalid_i,
   output logic               s_arready_o,
   output axil_data_t         s_rdata_o,
   output logic [1:0]         s_rresp_o,
   output logic               s_rvalid_o,
   input  logic               s_rready_i,
   output logic               native_req_o,
   output logic               native_we_o,
   output native_addr_t       native_addr_o,
   output axil_data_t         native_wdata_o,
   output axil_strb_t         native_wstrb_o,
   input  logic               native_ready_i,
   input  axil_data_t         native_rdata_i,
   input  logic               native_err_i
);
   typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP} state_e;
   state_e       state_q, state_d;
   native_req_t  req_q;
   axil_resp_e   bresp_q, rresp_q;
   axil_data_t   rdata_q;
   logic         last_rd_q;
   logic         aw_avail, w_avail, hold_block, hold_clr, idle, grant_wr, grant_rd, wr_in, rd_in;
   axil_addr_t   aw_data;
   logic [AXIL_STRB_WIDTH+AXIL_DATA_WIDTH-1:0] w_data;
   native_addr_t wr_addr, rd_addr;
   assign idle = state_q == IDLE;
   assign hold_block = rst_i || state_q == WR_RESP;
   assign hold_clr = state_q == WR_RESP && s_bready_i;
   vga_axil_hold #(.W(AXIL_ADDR_WIDTH)) u_aw_hold (
      .clk(clk_i), .rst(rst_i), .block(hold_block), .clr(hold_clr),
      .in_valid(s_awvalid_i), .in_data(s_awaddr_i), .in_ready(s_awready_o),
      .avail(aw_avail), .data(aw_data)
   );
   vga_axil_hold #(.W(AXIL_STRB_WIDTH+AXIL_DATA_WIDTH)) u_w_hold (
      .clk(clk_i), .rst(rst_i), .block(hold_block), .clr(hold_clr),
      .in_valid(s_wvalid_i), .in_data({s_wstrb_i, s_wdata_i}), .in_ready(s_wready_o),
      .avail(w_avail), .data(w_data)
   );
   // a holder being filled this cycle counts as full so the grant lands in cycle 0
   assign grant_wr = idle && aw_avail && w_avail && (!s_arvalid_i || last_rd_q);
   assign s_arready_o = idle && !grant_wr && !rst_i;
   assign grant_rd = s_arvalid_i && s_arready_o;
   assign wr_addr = axil2native_addr(aw_data);
   assign rd_addr = axil2native_addr(s_araddr_i);
   assign wr_in = wr_addr < native_addr_t'(NATIVE_DEPTH);
   assign rd_in = rd_addr < native_addr_t'(NATIVE_DEPTH);
   assign native_req_o = state_q == WR_REQ || state_q == RD_REQ;
   assign native_we_o = req_q.we;
   assign native_addr_o = req_q.addr;
   assign native_wdata_o = req_q.wdata;
   assign native_wstrb_o = req_q.wstrb;
   assign s_bvalid_o = state_q == WR_RESP;
   assign s_rvalid_o = state_q == RD_RESP;
   assign s_bresp_o = bresp_q;
   assign s_rresp_o = rresp_q;
   assign s_rdata_o = rdata_q;
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = grant_wr ? (wr_in ? WR_REQ : WR_RESP) : grant_rd ? (rd_in ? RD_REQ : RD_RESP) : IDLE;
         WR_REQ:  state_d = native_ready_i ? WR_RESP : WR_REQ;
         WR_RESP: state_d = s_bready_i ? IDLE : WR_RESP;
         RD_REQ:  state_d = native_ready_i ? RD_RESP : RD_REQ;
         RD_RESP: state_d = s_rready_i ? IDLE : RD_RESP;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         last_rd_q <= 1'b1;
         req_q <= '0;
         bresp_q <= OKAY;
         rresp_q <= OKAY;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         if (grant_wr) begin
            last_rd_q <= 1'b0;
            req_q <= '{we: 1'b1, addr: wr_addr, wdata: w_data[AXIL_DATA_WIDTH-1:0], wstrb: w_data[AXIL_STRB_WIDTH+AXIL_DATA_WIDTH-1:AXIL_DATA_WIDTH]};
            bresp_q <= wr_in ? OKAY : SLVERR;
         end else if (grant_rd) begin
            last_rd_q <= 1'b1;
            req_q <= '{we: 1'b0, addr: rd_addr, wdata: '0, wstrb: '0};
            rresp_q <= rd_in ? OKAY : SLVERR;
            rdata_q <= '0;
         end
         if (state_q == WR_REQ && native_ready_i) bresp_q <= native_err_i ? SLVERR : OKAY;
         if (state_q == RD_REQ && native_ready_i) begin
            rresp_q <= native_err_i ? SLVERR : OKAY;
            rdata_q <= native_err_i ? '0 : native_rdata_i;
         end
      end
   end
endmodule

// File: doc/vga_axil_slave.md
# vga_axil_slave

AXI4-Lite slave front-end for the VGA control/status register space. It accepts AXI4-Lite write and read transactions from the system interconnect and converts each one into a single word-addressed native register access. It returns OKAY or SLVERR responses. It sits directly upstream of the VGA register file and uses the shared AXI-Lite types and address-conversion function.

## Interface
- NATIVE_DEPTH, 16: number of valid native word addresses; native addresses at or above this get SLVERR without a native access.
- clk_i  in  1  single clock; all logic rising-edge.
- rst_i  in  1  synchronous reset, active-high.
- s_awaddr_i / s_awvalid_i / s_awready_o  in/in/out  32/1/1  write address channel.
- s_wdata_i / s_wstrb_i / s_wvalid_i / s_wready_o  in/in/in/out  32/4/1/1  write data channel.
- s_bresp_o / s_bvalid_o / s_bready_i  out/out/in  2/1/1  write response channel.
- s_araddr_i / s_arvalid_i / s_arready_o  in/in/out  32/1/1  read address channel.
- s_rdata_o / s_rresp_o / s_rvalid_o / s_rready_i  out/out/out/in  32/2/1/1  read data channel.
- native_req_o  out  1  native access request; held until accepted.
- native_we_o  out  1  1 = write, 0 = read.
- native_addr_o  out  29  native word address, equal to axil2native_addr(axaddr).
- native_wdata_o / native_wstrb_o  out  32/4  write data and byte strobes.
- native_ready_i  in  1  native side completes the access in this cycle.
- native_rdata_i / native_err_i  in  32/1  read data and error, sampled only when native_req_o & native_ready_i.

## Operation
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP.
- AW and W channels are captured independently into one-entry holding registers, in either order or in the same cycle.
- s_awready_o = AW holder empty and state != WR_RESP. s_wready_o is defined the same way for the W holder.
- s_arready_o = 1 only in IDLE when no write is being granted that cycle.
- Arbitration in IDLE:
  - A write is ready when both holders are full. A read is ready when s_arvalid_i is high.
  - If both are ready, grant the opposite of the last granted type. After reset the last granted type is read, so the first tie goes to write.
- Write path:
  - If the native address is < NATIVE_DEPTH, go to WR_REQ. Stay there with native_req_o=1 and native_we_o=1 until native_ready_i. Then bresp = native_err_i ? SLVERR : OKAY and go to WR_RESP.
  - If the native address is out of range, skip WR_REQ and go straight to WR_RESP with SLVERR.
- Read path: same structure via RD_REQ and RD_RESP.
  - rdata = native_rdata_i on success.
  - rdata = 32'h0 on native error or out-of-range address, with rresp = SLVERR.
- WR_RESP holds s_bvalid_o=1 until s_bready_i. In that cycle, clear both holders and return to IDLE. RD_RESP behaves the same with s_rvalid_o and s_rready_i.
- Only OKAY (2'b00) and SLVERR (2'b10) are ever produced.
- Native outputs addr, we, wdata and wstrb are registered and stable for the whole time native_req_o is high.

## Timing
- Reset values:
  - All ready and valid outputs are 0, and native_req_o is 0.
  - Data, response, address and strobe outputs are 0.
  - The FSM is in IDLE and the holders are empty.
- Reset asserted mid-transaction aborts the transaction: no response is issued and native_req_o drops in the next cycle.
- Write latency:
  - Cycle 0: AW and W handshakes complete.
  - Cycle 1: native_req_o=1.
  - If native_ready_i=1 in cycle 1, s_bvalid_o=1 in cycle 2.
- Read latency is the same: AR handshake in cycle 0, native_req_o in cycle 1, s_rvalid_o in cycle 2 at minimum.
- Out-of-range access: response valid in cycle 1 with no native_req_o pulse.
- One outstanding transaction in total. A new address is not accepted while a response is pending.
- AW may arrive during RD_REQ or RD_RESP and be held. The write is granted on the first IDLE cycle after the read response completes.
- Responses stay stable while valid is high and ready is low.

## Structure
- vga_axil_pkg already supplies axil_addr_t, axil_data_t, axil_resp_e (OKAY/SLVERR) and axil2native_addr. Add these to it:
  - AXIL_STRB_WIDTH = AXIL_DATA_WIDTH/8 and axil_strb_t.
  - The native request struct (we, addr, wdata, wstrb).
- FSM state enum is local to the module.
- One sub-module: vga_axil_hold, a one-entry valid/ready holding register instantiated for the AW and W channels.

## Test plan
- Write to 0x10 with data 0xDEADBEEF, strb 0xF, AW and W in the same cycle, native_ready_i=1 immediately:
  - native_addr_o=2 and native_wdata_o=0xDEADBEEF in cycle 1.
  - bvalid with OKAY in cycle 2.
- W arrives 3 cycles before AW, address 0x08: native write to address 1 occurs only after AW arrives, followed by OKAY.
- Read from 0x18, native_ready_i delayed 4 cycles, native_rdata_i=0x12345678, s_rready_i low for 2 cycles:
  - native_req_o is held for 5 cycles.
  - rvalid and rdata stay stable until the handshake.
- Read to address 0x80 (native 16, out of range): no native_req_o; rvalid with SLVERR and rdata=0 in cycle 1.
- Write with native_err_i=1 in the ready cycle gives SLVERR.
- Simultaneous write and read ready from reset: write is served first, then the read, with responses in that order.
- Assert rst_i during WR_REQ: all outputs return to 0 the next cycle and no bvalid is ever issued.
